fb_write_arbiter: RTL and testbench

Shares the single-port framebuffer RAM (word region 0xE00–0xF2B, 20×15 blocks) between the VGA scan-out path and processor stores. VGA reads own the RAM whenever the sync generator reports the visible area. Processor writes are queued in a small FIFO and retired only in blanking cycles. A hardware screen-clear sequencer fills the whole region with one colour word, ordered with respect to queued writes.

---
 rtl/fb_arb_pkg.sv | 17 +
 rtl/fb_wr_fifo.sv | 45 ++++
 rtl/fb_write_arbiter.sv | 138 +++++++++++++
 tb/tb_fb_write_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_arb_pkg.sv
// fb_arb_pkg: sequencer states, framebuffer geometry and address range check
package fb_arb_pkg;

    typedef enum logic [1:0] {IDLE, CLR_PEND, CLEAR} state_e;

    localparam logic [11:0] FB_BASE  = 12'hE00;
    localparam int          FB_WORDS = 300;

    function automatic logic fb_in_range(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] words
    );
        return (addr >= base) && (addr < base + words);
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// fb_wr_fifo: synchronous store queue with level output and same-cycle push/pop
module fb_wr_fifo #(
    parameter int  W     = 44,
    parameter int  DEPTH = 8,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [W-1:0]     wdata_i,
    output logic [W-1:0]     rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [LVL_W-1:0] level_q;

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_q + PTR_W'(push_i);
            rd_q    <= rd_q + PTR_W'(pop_i);
            level_q <= level_q + LVL_W'(push_i) - LVL_W'(pop_i);
        end
    end

    assign rdata_o = mem_q[rd_q];
    assign full_o  = level_q == LVL_W'(DEPTH);
    assign empty_o = level_q == '0;
    assign level_o = level_q;

endmodule

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: shares the framebuffer RAM between VGA scan-out, queued
// processor stores and a screen-clear fill sequencer
module fb_write_arbiter #(
    parameter int                ADDR_W     = 12,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] FB_BASE    = ADDR_W'(fb_arb_pkg::FB_BASE),
    parameter int                FB_WORDS   = fb_arb_pkg::FB_WORDS,
    parameter int                FIFO_DEPTH = 8,
    localparam int               LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              vga_active,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              cpu_wr_valid,
    output logic              cpu_wr_ready,
    input  logic [ADDR_W-1:0] cpu_wr_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic              cpu_wr_err,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_data,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [LVL_W-1:0]  fifo_level,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    import fb_arb_pkg::*;

    localparam int PTR_W = $clog2(FB_WORDS);

    state_e            state_q, state_d;
    logic [LVL_W-1:0]  pend_q, pend_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic              err_q, done_q, done_d;
    logic              accept, in_fb, push, pop, blank, full, empty;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    assign in_fb        = fb_in_range(32'(cpu_wr_addr), 32'(FB_BASE), 32'(FB_WORDS));
    assign cpu_wr_ready = ~full & ~reset;
    assign accept       = cpu_wr_valid & cpu_wr_ready;
    assign push         = accept & in_fb;
    assign blank        = ~reset & ~vga_active;

    fb_wr_fifo #(
        .W     (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (vga_clk),
        .rst_i   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({cpu_wr_addr, cpu_wr_data}),
        .rdata_o ({head_addr, head_data}),
        .full_o  (full),
        .empty_o (empty),
        .level_o (fifo_level)
    );

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        ptr_d     = ptr_q;
        fill_d    = fill_q;
        done_d    = 1'b0;
        pop       = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = vga_addr;
        mem_wdata = head_data;
        unique case (state_q)
            IDLE: begin
                pop = blank & ~empty;
                // Entries still queued when the clear is requested must land before the fill
                if (clr_start) begin
                    fill_d  = clr_data;
                    pend_d  = fifo_level + LVL_W'(push) - LVL_W'(pop);
                    state_d = CLR_PEND;
                end
            end
            CLR_PEND: begin
                pop    = blank & (pend_q != '0);
                pend_d = pend_q - LVL_W'(pop);
                if (pend_q == '0) begin
                    ptr_d   = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (blank) begin
                    mem_we    = 1'b1;
                    mem_addr  = FB_BASE + ADDR_W'(ptr_q);
                    mem_wdata = fill_q;
                    ptr_d     = ptr_q + 1'b1;
                    if (ptr_q == PTR_W'(FB_WORDS - 1)) begin
                        ptr_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            mem_we   = 1'b1;
            mem_addr = head_addr;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= '0;
            ptr_q   <= '0;
            fill_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
            fill_q  <= fill_d;
            err_q   <= accept & ~in_fb;
            done_q  <= done_d;
        end
    end

    assign vga_rdata  = mem_rdata;
    assign cpu_wr_err = err_q;
    assign clr_done   = done_q;
    assign clr_busy   = state_q != IDLE;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter: directed scenario tests for fb_write_arbiter with a RAM model
module tb_fb_write_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          vga_clk = 1'b0;
    logic          reset = 1'b1;
    logic          vga_active = 1'b1;
    logic [AW-1:0] vga_addr = '0;
    logic [DW-1:0] vga_rdata;
    logic          cpu_wr_valid = 1'b0;
    logic          cpu_wr_ready;
    logic [AW-1:0] cpu_wr_addr = '0;
    logic [DW-1:0] cpu_wr_data = '0;
    logic          cpu_wr_err;
    logic          clr_start = 1'b0;
    logic [DW-1:0] clr_data = '0;
    logic          clr_busy;
    logic          clr_done;
    logic [3:0]    fifo_level;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    int vectors = 0;
    int miscompares = 0;

    logic [AW+DW-1:0] wlog[$];
    logic [DW-1:0]    ram [0:4095];

    fb_write_arbiter dut (
        .vga_clk      (vga_clk),
        .reset        (reset),
        .vga_active   (vga_active),
        .vga_addr     (vga_addr),
        .vga_rdata    (vga_rdata),
        .cpu_wr_valid (cpu_wr_valid),
        .cpu_wr_ready (cpu_wr_ready),
        .cpu_wr_addr  (cpu_wr_addr),
        .cpu_wr_data  (cpu_wr_data),
        .cpu_wr_err   (cpu_wr_err),
        .clr_start    (clr_start),
        .clr_data     (clr_data),
        .clr_busy     (clr_busy),
        .clr_done     (clr_done),
        .fifo_level   (fifo_level),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata)
    );

    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            wlog.push_back({mem_addr, mem_wdata});
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        cpu_wr_valid = 1'b1;
        cpu_wr_addr  = a;
        cpu_wr_data  = d;
        #1;
        while (!cpu_wr_ready && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) begin
            vectors++; miscompares++;
            $display("FAIL push_timeout: ready stayed %0b, required 1", cpu_wr_ready);
        end
        tick();
        cpu_wr_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        vectors++; if (cpu_wr_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %0b required 0", cpu_wr_ready); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_we: got %0b required 0", mem_we); end
        vectors++; if (clr_busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %0b required 0", clr_busy); end
        vectors++; if (clr_done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %0b required 0", clr_done); end
        vectors++; if (cpu_wr_err !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %0b required 0", cpu_wr_err); end
        vectors++; if (fifo_level !== 4'd0) begin miscompares++; $display("FAIL rst_level: got %0d required 0", fifo_level); end
        reset = 1'b0;
        #1;
        vectors++; if (cpu_wr_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready_after: got %0b required 1", cpu_wr_ready); end
    endtask

    task automatic test_latency();
        vga_active = 1'b0;
        push(12'hE00, 32'h1);
        vectors++; if (mem_we !== 1'b1 || mem_addr !== 12'hE00 || mem_wdata !== 32'h1) begin miscompares++; $display("FAIL lat_write: got we=%0b addr=%0h data=%0h required 1/e00/1", mem_we, mem_addr, mem_wdata); end
        vectors++; if (fifo_level !== 4'd1) begin miscompares++; $display("FAIL lat_level: got %0d required 1", fifo_level); end
        tick();
        vectors++; if (mem_we !== 1'b0 || fifo_level !== 4'd0) begin miscompares++; $display("FAIL lat_drained: got we=%0b level=%0d required 0/0", mem_we, fifo_level); end
        push(12'hF2B, 32'h2);
        vectors++; if (mem_we !== 1'b1 || mem_addr !== 12'hF2B || cpu_wr_err !== 1'b0) begin miscompares++; $display("FAIL lat_top_word: got we=%0b addr=%0h err=%0b required 1/f2b/0", mem_we, mem_addr, cpu_wr_err); end
        tick();
    endtask

    task automatic test_stall();
        vga_active = 1'b1;
        wlog.delete();
        push(12'hE05, 32'h11);
        push(12'hE06, 32'h22);
        push(12'hE07, 32'h33);
        vectors++; if (fifo_level !== 4'd3) begin miscompares++; $display("FAIL stall_level: got %0d required 3", fifo_level); end
        vectors++; if (wlog.size() != 0 || mem_we !== 1'b0) begin miscompares++; $display("FAIL stall_no_write: got writes=%0d we=%0b required 0/0", wlog.size(), mem_we); end
        vga_active = 1'b0;
        #1;
        vectors++; if (mem_we !== 1'b1 || mem_addr !== 12'hE05) begin miscompares++; $display("FAIL stall_w0: got we=%0b addr=%0h required 1/e05", mem_we, mem_addr); end
        tick();
        vectors++; if (mem_we !== 1'b1 || mem_addr !== 12'hE06) begin miscompares++; $display("FAIL stall_w1: got we=%0b addr=%0h required 1/e06", mem_we, mem_addr); end
        tick();
        vectors++; if (mem_we !== 1'b1 || mem_addr !== 12'hE07 || mem_wdata !== 32'h33) begin miscompares++; $display("FAIL stall_w2: got we=%0b addr=%0h data=%0h required 1/e07/33", mem_we, mem_addr, mem_wdata); end
        tick();
        vectors++; if (mem_we !== 1'b0 || fifo_level !== 4'd0) begin miscompares++; $display("FAIL stall_end: got we=%0b level=%0d required 0/0", mem_we, fifo_level); end
        vga_active = 1'b1;
        vga_addr   = 12'hE06;
        tick();
        vectors++; if (vga_rdata !== 32'h22) begin miscompares++; $display("FAIL stall_readback: got %0h required 22", vga_rdata); end
    endtask

    task automatic test_backpressure();
        vga_active = 1'b1;
        wlog.delete();
        for (int i = 0; i < 8; i++) push(12'hE20 + 12'(i), 32'h100 + 32'(i));
        vectors++; if (fifo_level !== 4'd8 || cpu_wr_ready !== 1'b0) begin miscompares++; $display("FAIL bp_full: got level=%0d ready=%0b required 8/0", fifo_level, cpu_wr_ready); end
        cpu_wr_valid = 1'b1;
        cpu_wr_addr  = 12'hE28;
        cpu_wr_data  = 32'h108;
        tick();
        tick();
        vectors++; if (fifo_level !== 4'd8 || cpu_wr_ready !== 1'b0) begin miscompares++; $display("FAIL bp_held: got level=%0d ready=%0b required 8/0", fifo_level, cpu_wr_ready); end
        vga_active = 1'b0;
        #1;
        vectors++; if (mem_we !== 1'b1 || mem_addr !== 12'hE20) begin miscompares++; $display("FAIL bp_drain: got we=%0b addr=%0h required 1/e20", mem_we, mem_addr); end
        tick();
        vga_active = 1'b1;
        #1;
        vectors++; if (fifo_level !== 4'd7 || cpu_wr_ready !== 1'b1) begin miscompares++; $display("FAIL bp_room: got level=%0d ready=%0b required 7/1", fifo_level, cpu_wr_ready); end
        tick();
        cpu_wr_valid = 1'b0;
        vectors++; if (fifo_level !== 4'd8) begin miscompares++; $display("FAIL bp_ninth: got level=%0d required 8", fifo_level); end
        vga_active = 1'b0;
        for (int n = 0; n < 50 && fifo_level != 4'd0; n++) tick();
        tick();
        vectors++; if (wlog.size() != 9) begin miscompares++; $display("FAIL bp_count: got %0d writes required 9", wlog.size()); end
        else begin
            int bad = 0;
            for (int i = 0; i < 9; i++) if (wlog[i] !== {12'hE20 + 12'(i), 32'h100 + 32'(i)}) bad++;
            vectors++; if (bad != 0) begin miscompares++; $display("FAIL bp_order: got %0d out-of-order writes required 0", bad); end
        end
    endtask

    task automatic test_oob();
        vga_active = 1'b0;
        wlog.delete();
        push(12'hDFF, 32'hAA);
        vectors++; if (cpu_wr_err !== 1'b1 || mem_we !== 1'b0 || fifo_level !== 4'd0) begin miscompares++; $display("FAIL oob_low: got err=%0b we=%0b level=%0d required 1/0/0", cpu_wr_err, mem_we, fifo_level); end
        tick();
        vectors++; if (cpu_wr_err !== 1'b0) begin miscompares++; $display("FAIL oob_low_pulse: got err=%0b required 0", cpu_wr_err); end
        push(12'hF2C, 32'hBB);
        vectors++; if (cpu_wr_err !== 1'b1 || mem_we !== 1'b0 || fifo_level !== 4'd0) begin miscompares++; $display("FAIL oob_high: got err=%0b we=%0b level=%0d required 1/0/0", cpu_wr_err, mem_we, fifo_level); end
        tick();
        tick();
        vectors++; if (cpu_wr_err !== 1'b0 || wlog.size() != 0) begin miscompares++; $display("FAIL oob_quiet: got err=%0b writes=%0d required 0/0", cpu_wr_err, wlog.size()); end
    endtask

    task automatic test_clear_order();
        int done_cnt = 0;
        int early_drop = 0;
        int bad = 0;
        vga_active = 1'b1;
        wlog.delete();
        push(12'hE10, 32'hA);
        push(12'hE11, 32'hB);
        clr_start = 1'b1;
        clr_data  = 32'h4;
        tick();
        clr_start = 1'b0;
        clr_data  = 32'h0;
        vectors++; if (clr_busy !== 1'b1) begin miscompares++; $display("FAIL ord_busy: got %0b required 1", clr_busy); end
        push(12'hE12, 32'hC);
        vga_active = 1'b0;
        for (int n = 0; n < 400; n++) begin
            tick();
            if (clr_done) done_cnt++;
            if (!clr_done && done_cnt == 0 && !clr_busy) early_drop++;
        end
        vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL ord_done: got %0d pulses required 1", done_cnt); end
        vectors++; if (early_drop != 0) begin miscompares++; $display("FAIL ord_busy_span: got %0d idle cycles before done required 0", early_drop); end
        vectors++; if (wlog.size() != 303) begin miscompares++; $display("FAIL ord_count: got %0d writes required 303", wlog.size()); end
        else begin
            vectors++; if (wlog[0] !== {12'hE10, 32'hA} || wlog[1] !== {12'hE11, 32'hB}) begin miscompares++; $display("FAIL ord_head: got %0h %0h required e1000000000a e1100000000b", wlog[0], wlog[1]); end
            for (int i = 0; i < 300; i++) if (wlog[2+i] !== {12'hE00 + 12'(i), 32'h4}) bad++;
            vectors++; if (bad != 0) begin miscompares++; $display("FAIL ord_fill: got %0d bad fill words required 0", bad); end
            vectors++; if (wlog[302] !== {12'hE12, 32'hC}) begin miscompares++; $display("FAIL ord_tail: got %0h required e1200000000c", wlog[302]); end
        end
    endtask

    task automatic test_clear_blanking();
        int fills = 0, bad_active = 0, bad_fill = 0, done_cnt = 0, done_c = -1, last_wr = -1;
        for (int c = 0; c < 1200; c++) begin
            vga_active = (c % 800) >= 160;
            clr_start  = (c == 0) || (c == 5);
            clr_data   = (c == 0) ? 32'h5 : 32'h9;
            #1;
            if (mem_we) begin
                if (vga_active) bad_active++;
                if (mem_addr !== 12'hE00 + 12'(fills) || mem_wdata !== 32'h5) bad_fill++;
                fills++;
                last_wr = c;
            end
            if (clr_done) begin
                done_cnt++;
                done_c = c;
            end
            tick();
        end
        clr_start  = 1'b0;
        vga_active = 1'b0;
        vectors++; if (fills != 300) begin miscompares++; $display("FAIL blk_fills: got %0d required 300", fills); end
        vectors++; if (bad_active != 0) begin miscompares++; $display("FAIL blk_active_write: got %0d required 0", bad_active); end
        vectors++; if (bad_fill != 0) begin miscompares++; $display("FAIL blk_fill_seq: got %0d bad words required 0", bad_fill); end
        vectors++; if (done_cnt != 1 || done_c != last_wr + 1) begin miscompares++; $display("FAIL blk_done: got pulses=%0d at %0d required 1 at %0d", done_cnt, done_c, last_wr + 1); end
        vectors++; if (clr_busy !== 1'b0) begin miscompares++; $display("FAIL blk_busy_end: got %0b required 0", clr_busy); end
    endtask

    task automatic test_reset_mid_clear();
        vga_active = 1'b0;
        wlog.delete();
        clr_start = 1'b1;
        clr_data  = 32'h7;
        tick();
        clr_start = 1'b0;
        for (int n = 0; n < 400 && wlog.size() < 150; n++) tick();
        vga_active = 1'b1;
        #1;
        vectors++; if (wlog.size() != 150 || wlog[149] !== {12'hE00 + 12'd149, 32'h7}) begin miscompares++; $display("FAIL mid_progress: got %0d writes required 150", wlog.size()); end
        push(12'hE30, 32'h30);
        push(12'hE31, 32'h31);
        vectors++; if (fifo_level !== 4'd2 || clr_busy !== 1'b1) begin miscompares++; $display("FAIL mid_queued: got level=%0d busy=%0b required 2/1", fifo_level, clr_busy); end
        reset      = 1'b1;
        vga_active = 1'b0;
        #1;
        vectors++; if (mem_we !== 1'b0 || cpu_wr_ready !== 1'b0) begin miscompares++; $display("FAIL mid_rst_cycle: got we=%0b ready=%0b required 0/0", mem_we, cpu_wr_ready); end
        tick();
        reset = 1'b0;
        #1;
        vectors++; if (clr_busy !== 1'b0 || fifo_level !== 4'd0 || mem_we !== 1'b0) begin miscompares++; $display("FAIL mid_after: got busy=%0b level=%0d we=%0b required 0/0/0", clr_busy, fifo_level, mem_we); end
        wlog.delete();
        for (int n = 0; n < 20; n++) tick();
        vectors++; if (wlog.size() != 0 || clr_done !== 1'b0) begin miscompares++; $display("FAIL mid_no_writes: got writes=%0d done=%0b required 0/0", wlog.size(), clr_done); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_latency();
        test_stall();
        test_backpressure();
        test_oob();
        test_clear_order();
        test_clear_blanking();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
